pcpi_mul_arbiter: RTL and testbench

- Shares one PCPI multiply unit among NREQ requester PCPI ports, e.g. several cores or hart contexts. Only the multiplier instances are shared.
- Filters incoming instructions to the M-extension multiply group and grants the shared unit round-robin.
- Forwards the granted operation downstream and routes the result back to the granted requester only.
- Sits between the requesters' PCPI buses and a single downstream multiplier.

---
 rtl/mul_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/pcpi_mul_arbiter.sv | 133 +++++++++++++
 tb/tb_pcpi_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared constants, FSM state type and M-extension multiply decode for pcpi_mul_arbiter.
package mul_arb_pkg;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
`ifdef MUL_ARB_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;
  function automatic logic is_mul_insn(input logic [31:0] insn);
    return insn[6:0] == OPC_OP && insn[31:25] == F7_MULDIV && !insn[14];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap-around.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[(int'(last) + k) % NREQ]) begin
        any = 1'b1;
        idx = $clog2(NREQ)'((int'(last) + k) % NREQ);
        gnt[(int'(last) + k) % NREQ] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pcpi_mul_arbiter.sv
// pcpi_mul_arbiter: shares one downstream PCPI multiplier among NREQ requesters, round-robin.
// Define MUL_ARB_TIMEOUT_EN to add the WAIT watchdog, DRAIN state and timeout_seen status.
module pcpi_mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = 64,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      s_valid,
  input  logic [32*NREQ-1:0]   s_insn,
  input  logic [32*NREQ-1:0]   s_rs1,
  input  logic [32*NREQ-1:0]   s_rs2,
  output logic [NREQ-1:0]      s_wr,
  output logic [32*NREQ-1:0]   s_rd,
  output logic [NREQ-1:0]      s_wait,
  output logic [NREQ-1:0]      s_ready,
  output logic                 m_valid,
  output logic [31:0]          m_insn,
  output logic [31:0]          m_rs1,
  output logic [31:0]          m_rs2,
`ifdef MUL_ARB_TIMEOUT_EN
  output logic                 timeout_seen,
`endif
  input  logic                 m_wr,
  input  logic [31:0]          m_rd,
  input  logic                 m_ready
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_n;
  logic [NREQ-1:0] elig, gnt, sel;
  logic [IW-1:0] idx, last;
  logic any, wr_q;
  logic [31:0] rd_q;
`ifdef MUL_ARB_TIMEOUT_EN
  logic [31:0] cnt;
  logic to_q, expired;
  assign expired = state == WAIT && !m_ready && cnt == 32'(TIMEOUT - 1);
`endif

  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || DRAIN_CYCLES < 1) begin : g_bad_cfg
      $error("pcpi_mul_arbiter: NREQ must be 2..8, TIMEOUT and DRAIN_CYCLES at least 1");
    end
  endgenerate

  always_comb
    for (int i = 0; i < NREQ; i++)
      elig[i] = s_valid[i] && is_mul_insn(s_insn[32*i +: 32]);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (elig),
    .last(last),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = any ? WAIT : IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
      WAIT: state_n = (m_ready || expired) ? RESP : WAIT;
      RESP: state_n = to_q ? DRAIN : IDLE;
      DRAIN: state_n = cnt == 32'(DRAIN_CYCLES - 1) ? IDLE : DRAIN;
`else
      WAIT: state_n = m_ready ? RESP : WAIT;
      RESP: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      last <= IW'(NREQ - 1);
      rd_q <= '0;
      wr_q <= 1'b0;
      m_valid <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt <= '0;
      to_q <= 1'b0;
      timeout_seen <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        sel <= gnt;
        last <= idx;
        m_valid <= 1'b1;
      end
      // m_valid falls on the same edge that samples m_ready so the op is never reissued
      if (state == WAIT && m_ready) begin
        rd_q <= m_rd;
        wr_q <= m_wr;
        m_valid <= 1'b0;
      end
`ifdef MUL_ARB_TIMEOUT_EN
      cnt <= (state == WAIT || state == DRAIN) ? cnt + 32'd1 : '0;
      if (state == IDLE) to_q <= 1'b0;
      if (expired) begin
        rd_q <= '0;
        wr_q <= 1'b0;
        m_valid <= 1'b0;
        to_q <= 1'b1;
        timeout_seen <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    m_insn = '0;
    m_rs1 = '0;
    m_rs2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_ready[i] = state == RESP && sel[i];
      s_wr[i] = s_ready[i] && wr_q;
      s_rd[32*i +: 32] = s_ready[i] ? rd_q : '0;
      s_wait[i] = elig[i] && !s_ready[i];
      if (m_valid && sel[i]) begin
        m_insn = s_insn[32*i +: 32];
        m_rs1 = s_rs1[32*i +: 32];
        m_rs2 = s_rs2[32*i +: 32];
      end
    end
  end
endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// tb_pcpi_mul_arbiter: scoreboard bench with a behavioural downstream multiplier.
module tb_pcpi_mul_arbiter;
  localparam int N = 2;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] s_valid, s_wr, s_wait, s_ready;
  logic [32*N-1:0] s_insn, s_rs1, s_rs2, s_rd;
  logic m_valid, m_wr, m_ready;
  logic [31:0] m_insn, m_rs1, m_rs2, m_rd;
`ifdef MUL_ARB_TIMEOUT_EN
  logic timeout_seen;
`endif
  typedef struct {
    int idx;
    logic [31:0] rd;
    logic wr;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, issues = 0, readies = 0, wc = 0;
  int req_seq[N], ack_seq[N];
  logic stuck = 1'b0, stray = 1'b0, prev_mv = 1'b0;

  always #5 clk = ~clk;

  pcpi_mul_arbiter #(.NREQ(N), .TIMEOUT(8), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_insn(s_insn), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_wr(s_wr), .s_rd(s_rd), .s_wait(s_wait), .s_ready(s_ready),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
`ifdef MUL_ARB_TIMEOUT_EN
    .timeout_seen(timeout_seen),
`endif
    .m_wr(m_wr), .m_rd(m_rd), .m_ready(m_ready)
  );

  // a requester holds s_valid from issue until it has seen its s_ready
  always_comb
    for (int i = 0; i < N; i++) s_valid[i] = req_seq[i] > ack_seq[i];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'd1: p = longint'($signed(a)) * longint'($signed(b));
      3'd2: p = longint'($signed(a)) * longint'({32'b0, b});
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return f == 3'd0 ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic issue(input int r, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit track);
    s_insn[32*r +: 32] = mk(f3);
    s_rs1[32*r +: 32] = a;
    s_rs2[32*r +: 32] = b;
    req_seq[r] = ack_seq[r] + 1;
    if (track) sb.push_back('{r, ref_mul(f3, a, b), 1'b1});
  endtask

  task automatic drain_wait(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("sb_empty", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    m_ready = 1'b0;
    m_wr = 1'b0;
    m_rd = '0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      m_wr = 1'b0;
      if (stray) begin
        m_ready = 1'b1;
        m_wr = 1'b1;
        m_rd = 32'h1234;
      end else if (m_valid && !stuck) begin
        wc++;
        if (wc >= 2) begin
          m_ready = 1'b1;
          m_wr = 1'b1;
          m_rd = ref_mul(m_insn[14:12], m_rs1, m_rs2);
          wc = 0;
        end
      end else wc = 0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid && !prev_mv) issues++;
      prev_mv = m_valid;
      if (s_ready != '0) begin
        readies++;
        chk("ready_onehot", 64'($countones(s_ready)), 1);
        chk("mv_at_ready", m_valid, 0);
        if (sb.size() == 0) chk("unexpected_ready", s_ready, 0);
        else begin
          e = sb.pop_front();
          chk("ready_idx", s_ready, 64'(1) << e.idx);
          chk("rd", s_rd[32*e.idx +: 32], e.rd);
          chk("wr", s_wr, e.wr ? 64'(1) << e.idx : 64'(0));
        end
        for (int i = 0; i < N; i++) if (s_ready[i]) ack_seq[i]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, i0, r0;
    reset = 1'b1;
    s_insn = '0;
    s_rs1 = '0;
    s_rs2 = '0;
    for (int i = 0; i < N; i++) begin
      req_seq[i] = 0;
      ack_seq[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s_wr", s_wr, 0);
    chk("rst_s_rd", s_rd, 0);
    chk("rst_m_insn", m_insn, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 3'd0, 32'd7, 32'd6, 1);
    chk("single_mv_pre", m_valid, 0);
    @(negedge clk);
    chk("single_mv", m_valid, 1);
    chk("single_m_rs1", m_rs1, 7);
    chk("single_wait0", s_wait[0], 1);
    drain_wait(50);

    issue(0, 3'd4, 32'd100, 32'd5, 0);
    repeat (4) begin
      @(negedge clk);
      chk("div_mv", m_valid, 0);
      chk("div_wait", s_wait[0], 0);
    end
    req_seq[0] = ack_seq[0];

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    issue(0, 3'd1, 32'h8000_0000, 32'd2, 1);
    issue(1, 3'd1, 32'h4000_0000, 32'd8, 1);
    @(negedge clk);
    chk("cont_wait0", s_wait[0], 1);
    repeat (4) begin
      chk("cont_wait1", s_wait[1], 1);
      @(negedge clk);
    end
    drain_wait(50);
    issue(0, 3'd0, 32'h1234_5678, 32'h10, 1);
    drain_wait(50);
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(0, 3'd0, 32'd3, 32'd5, 1);
    sb[0].idx = 1;
    drain_wait(50);

    i0 = issues;
    r0 = readies;
    issue(1, 3'd0, 32'd9, 32'd9, 1);
    n = 0;
    while (ack_seq[1] != req_seq[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    drain_wait(50);
    repeat (3) @(negedge clk);
    chk("b2b_issues", 64'(issues - i0), 2);
    chk("b2b_readies", 64'(readies - r0), 2);

    stuck = 1'b1;
    issue(1, 3'd0, 32'd2, 32'd2, 0);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rw_mv_up", m_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_mv", m_valid, 0);
    chk("rw_ready", s_ready, 0);
    reset = 1'b0;
    stuck = 1'b0;
    req_seq[1] = ack_seq[1];
    issue(0, 3'd0, 32'd11, 32'd3, 1);
    issue(1, 3'd0, 32'd13, 32'd2, 1);
    drain_wait(60);

`ifdef MUL_ARB_TIMEOUT_EN
    stuck = 1'b1;
    issue(0, 3'd0, 32'd4, 32'd4, 0);
    sb.push_back('{0, 32'd0, 1'b0});
    n = 0;
    for (int k = 0; k < 40 && !s_ready[0]; k++) begin
      @(negedge clk);
      if (m_valid) n++;
    end
    chk("to_wait_cycles", 64'(n), 8);
    chk("to_ready", s_ready[0], 1);
    chk("to_seen", timeout_seen, 1);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    stuck = 1'b0;
    repeat (6) @(negedge clk);
    chk("to_seen_sticky", timeout_seen, 1);
    issue(1, 3'd0, 32'd6, 32'd7, 1);
    drain_wait(50);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
